display_scan_ctrl: RTL

- Time-multiplexed scan controller for a common-segment multi-digit 7-segment display on the MIPS board.
- Shares one hex-to-segment decoder across NUM_DIGITS digits.
- Double-buffers the displayed value so updates apply only at frame boundaries (no tearing).
- Inserts a guard interval between digits to suppress ghosting; CPU/debug logic drives it with a load strobe.

---
 rtl/disp_pkg.sv | 29 ++
 rtl/seg7_hex_decode.sv | 32 +++
 rtl/display_scan_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller.
// Segment codes are active-low with bit 0 = segment a ... bit 6 = segment g.
package disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment decoder (bit 0 = a).
module seg7_hex_decode
  import disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed, double-buffered scan controller for a multi-digit 7-seg display.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the top nonzero nibble.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SW-1:0]                 r_slot_cnt;
  logic [DW-1:0]                 r_dig_idx;
  logic [NUM_DIGITS-1:0][3:0]    r_active;
  logic [NUM_DIGITS-1:0][3:0]    r_pending;
  logic                          r_pend_valid;
  logic [6:0]                    r_seg;
  logic [NUM_DIGITS-1:0]         r_dig_en;
  logic                          r_frame_done;

  logic                          w_slot_wrap;
  logic                          w_last_dig;
  logic                          w_frame_end;
  phase_e                        w_phase;
  logic [NUM_DIGITS-1:0]         w_dig_en;
  logic [NUM_DIGITS-1:0]         w_lz_blank;
  logic [NUM_DIGITS-1:0]         w_blank;
  logic                          w_zero_run;
  logic [3:0]                    w_nibble;
  logic [6:0]                    w_seg;

  assign w_slot_wrap = (r_slot_cnt == SW'(REFRESH_DIV - 1));
  assign w_last_dig  = (r_dig_idx == DW'(NUM_DIGITS - 1));
  assign w_frame_end = w_slot_wrap && w_last_dig;
  assign w_phase     = ((GUARD_CYCLES > 0) && (r_slot_cnt < SW'(GUARD_CYCLES))) ? PH_GUARD : PH_DRIVE;

  // Slot timer and digit pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt <= '0;
      r_dig_idx  <= '0;
    end else if (w_slot_wrap) begin
      r_slot_cnt <= '0;
      r_dig_idx  <= w_last_dig ? '0 : r_dig_idx + DW'(1);
    end else begin
      r_slot_cnt <= r_slot_cnt + SW'(1);
    end
  end

  // Old pending moves to active at the frame edge even when a new load lands on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_frame_end && r_pend_valid)
        r_active <= r_pending;
      if (load)
        r_pending <= value_in;
      if (load)
        r_pend_valid <= 1'b1;
      else if (w_frame_end)
        r_pend_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign w_dig_en[k] = !((w_phase == PH_DRIVE) && (r_dig_idx == DW'(k)));
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; blank while everything above is zero. Digit 0 stays lit.
  always_comb begin
    w_lz_blank = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zero_run    = w_zero_run && (r_active[k] == 4'h0);
      w_lz_blank[k] = w_zero_run;
    end
  end
`else
  assign w_zero_run = 1'b0;
  assign w_lz_blank = '0;
`endif

  assign w_blank  = blank_mask | w_lz_blank;
  assign w_nibble = r_active[r_dig_idx];

  seg7_hex_decode u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= SEG_OFF;
      r_dig_en     <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= ((w_phase == PH_GUARD) || w_blank[r_dig_idx] || w_zero_run && 1'b0) ? SEG_OFF : w_seg;
      r_dig_en     <= w_dig_en;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg_out    = r_seg;
  assign digit_en   = r_dig_en;
  assign frame_done = r_frame_done;

endmodule
